// File: rtl/sfx_tone_voice.sv
// sfx_tone_voice
//   Single sound-effect voice. A trigger starts a square-wave tone whose
//   amplitude decays linearly; the resulting sample is centred on mid-scale
//   and feeds a PWM stage's duty input directly. Samples update once every
//   SAMPLE_DIV clocks, in step with a 2^DUTY_WIDTH-clock PWM period.
//
// Configuration macro:
//   SFX_SWEEP_EN - when defined, every envelope decrement adds the latched
//                  sweep_step to the latched tone period (saturating).
//                  When undefined, sweep_step_i is ignored and no sweep
//                  logic is built.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset
//   trigger_i      1-cycle start/restart pulse
//   stop_i         abort playback (wins over trigger_i)
//   period_i       tone half-period in clk cycles (0 behaves as 1), latched
//   amplitude_i    initial envelope level, latched
//   decay_div_i    sample ticks per envelope decrement, 0 = sustain, latched
//   sweep_step_i   period increment per envelope step, latched
//   duty_o         sample to the PWM stage
//   sample_tick_o  1-cycle pulse on the cycle duty_o updates
//   busy_o         high while a note is playing
module sfx_tone_voice #(
    parameter int unsigned DUTY_WIDTH   = 8,
    parameter int unsigned PERIOD_WIDTH = 16,
    parameter int unsigned DECAY_WIDTH  = 8,
    parameter int unsigned SAMPLE_DIV   = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    trigger_i,
    input  logic                    stop_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    input  logic [DUTY_WIDTH-2:0]   amplitude_i,
    input  logic [DECAY_WIDTH-1:0]  decay_div_i,
    input  logic [PERIOD_WIDTH-1:0] sweep_step_i,
    output logic [DUTY_WIDTH-1:0]   duty_o,
    output logic                    sample_tick_o,
    output logic                    busy_o
);

    localparam int unsigned DivW = $clog2(SAMPLE_DIV);

    localparam logic [DivW-1:0]         DivMax = DivW'(SAMPLE_DIV - 1);
    localparam logic [DivW-1:0]         DivOne = {{(DivW-1){1'b0}}, 1'b1};
    localparam logic [DUTY_WIDTH-1:0]   Mid    = {1'b1, {(DUTY_WIDTH-1){1'b0}}};
    localparam logic [DUTY_WIDTH-2:0]   EnvOne = {{(DUTY_WIDTH-2){1'b0}}, 1'b1};
    localparam logic [PERIOD_WIDTH-1:0] PerOne = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DECAY_WIDTH-1:0]  DecOne = {{(DECAY_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {StIdle, StPlay} state_e;

    state_e                  state_q;
    logic [DivW-1:0]         div_q;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic [PERIOD_WIDTH-1:0] cnt_q;
    logic                    phase_q;
    logic [DUTY_WIDTH-2:0]   env_q;
    logic [DECAY_WIDTH-1:0]  decay_q;
    logic [DECAY_WIDTH-1:0]  dcnt_q;
    logic [DUTY_WIDTH-1:0]   duty_q;
    logic                    sample_tick_q;
    logic                    busy_q;

    logic                    tick;
    logic [PERIOD_WIDTH-1:0] tone_last;
    logic [DUTY_WIDTH-1:0]   env_ext;
    logic [DUTY_WIDTH-1:0]   duty_play;
    logic [DECAY_WIDTH-1:0]  dcnt_inc;

    assign tick      = (div_q == DivMax);
    // Terminal count of a half-period; period 0 terminates every clock like period 1.
    assign tone_last = (period_q == '0) ? '0 : period_q - PerOne;
    assign env_ext   = {1'b0, env_q};
    // env never exceeds MID-1, so neither side can wrap.
    assign duty_play = phase_q ? Mid + env_ext : Mid - env_ext;
    assign dcnt_inc  = dcnt_q + DecOne;

`ifdef SFX_SWEEP_EN
    logic [PERIOD_WIDTH-1:0] sweep_q;
    logic [PERIOD_WIDTH:0]   period_sum;
    logic [PERIOD_WIDTH-1:0] period_swept;

    assign period_sum   = {1'b0, period_q} + {1'b0, sweep_q};
    assign period_swept = period_sum[PERIOD_WIDTH] ? '1 : period_sum[PERIOD_WIDTH-1:0];
`else
    logic unused_sweep_step;
    assign unused_sweep_step = ^sweep_step_i;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            div_q         <= '0;
            period_q      <= '0;
            cnt_q         <= '0;
            phase_q       <= 1'b0;
            env_q         <= '0;
            decay_q       <= '0;
            dcnt_q        <= '0;
            duty_q        <= Mid;
            sample_tick_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef SFX_SWEEP_EN
            sweep_q       <= '0;
`endif
        end else begin
            // Sample divider free-runs in every state and is never restarted.
            div_q         <= div_q + DivOne;
            sample_tick_q <= tick;

            if (stop_i) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
                duty_q  <= Mid;
                cnt_q   <= '0;
                phase_q <= 1'b0;
                env_q   <= '0;
                dcnt_q  <= '0;
            end else begin
                // A tick coinciding with a trigger still emits the outgoing note's sample.
                if (tick) begin
                    if (state_q == StPlay && env_q != '0) begin
                        duty_q <= duty_play;
                    end else begin
                        duty_q <= Mid;
                    end
                end

                if (trigger_i) begin
                    state_q  <= StPlay;
                    busy_q   <= 1'b1;
                    period_q <= period_i;
                    decay_q  <= decay_div_i;
                    env_q    <= amplitude_i;
                    cnt_q    <= '0;
                    phase_q  <= 1'b0;
                    dcnt_q   <= '0;
`ifdef SFX_SWEEP_EN
                    sweep_q  <= sweep_step_i;
`endif
                end else if (state_q == StPlay) begin
                    if (cnt_q == tone_last) begin
                        cnt_q   <= '0;
                        phase_q <= ~phase_q;
                    end else begin
                        cnt_q <= cnt_q + PerOne;
                    end

                    if (tick) begin
                        if (env_q == '0) begin
                            // The note ends one tick after the envelope hits zero.
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end else if (decay_q != '0) begin
                            if (dcnt_inc == decay_q) begin
                                dcnt_q <= '0;
                                env_q  <= env_q - EnvOne;
`ifdef SFX_SWEEP_EN
                                period_q <= period_swept;
`endif
                            end else begin
                                dcnt_q <= dcnt_inc;
                            end
                        end
                    end
                end
            end
        end
    end

    assign duty_o        = duty_q;
    assign sample_tick_o = sample_tick_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_sfx_tone_voice.sv
// Testbench for sfx_tone_voice: reset checks, a table of single notes with
// hand-derived sample values, hand-written multi-cycle sequences, and a
// randomized run compared every cycle against a behavioural model.
module tb_sfx_tone_voice;

    localparam int DW  = 8;
    localparam int PW  = 16;
    localparam int KW  = 8;
    localparam int SD  = 16;
    localparam int MID = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          trig = 1'b0;
    logic          stp = 1'b0;
    logic [PW-1:0] per_v = '0;
    logic [DW-2:0] amp_v = '0;
    logic [KW-1:0] dec_v = '0;
    logic [PW-1:0] swp_v = '0;
    logic [DW-1:0] duty_o;
    logic          sample_tick_o;
    logic          busy_o;

    int checks = 0;
    int errors = 0;

    sfx_tone_voice #(
        .DUTY_WIDTH  (DW),
        .PERIOD_WIDTH(PW),
        .DECAY_WIDTH (KW),
        .SAMPLE_DIV  (SD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .trigger_i    (trig),
        .stop_i       (stp),
        .period_i     (per_v),
        .amplitude_i  (amp_v),
        .decay_div_i  (dec_v),
        .sweep_step_i (swp_v),
        .duty_o       (duty_o),
        .sample_tick_o(sample_tick_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    // Behavioural model: note parameters and elapsed-time counters as plain integers.
    int m_div = 0, m_play = 0, m_elapsed = 0, m_phase = 0, m_env = 0, m_steps = 0;
    int m_per = 0, m_dec = 0, m_swp = 0, m_duty = MID, m_stick = 0;

    task automatic model_step();
        int tk;
        int half;
        if (rst) begin
            m_div = 0; m_play = 0; m_elapsed = 0; m_phase = 0; m_env = 0; m_steps = 0;
            m_per = 0; m_dec = 0; m_swp = 0; m_duty = MID; m_stick = 0;
            return;
        end
        tk      = (m_div == SD - 1) ? 1 : 0;
        m_div   = (m_div + 1) % SD;
        m_stick = tk;
        if (stp) begin
            m_play = 0;
            m_duty = MID;
            return;
        end
        if (tk != 0)
            m_duty = (m_play != 0 && m_env != 0) ? (m_phase != 0 ? MID + m_env : MID - m_env) : MID;
        if (trig) begin
            m_play = 1; m_elapsed = 0; m_phase = 0; m_steps = 0;
            m_per = int'(per_v); m_dec = int'(dec_v); m_swp = int'(swp_v); m_env = int'(amp_v);
        end else if (m_play != 0) begin
            half = (m_per == 0) ? 1 : m_per;
            m_elapsed++;
            if (m_elapsed >= half) begin
                m_elapsed = 0;
                m_phase   = 1 - m_phase;
            end
            if (tk != 0) begin
                if (m_env == 0) begin
                    m_play = 0;
                end else if (m_dec != 0) begin
                    m_steps++;
                    if (m_steps == m_dec) begin
                        m_steps = 0;
                        m_env--;
`ifdef SFX_SWEEP_EN
                        m_per = (m_per + m_swp > 65535) ? 65535 : m_per + m_swp;
`endif
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance model alongside DUT, then compare all outputs.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("lockstep{duty,busy,tick}", {22'd0, duty_o, busy_o, sample_tick_o},
            m_duty * 4 + m_play * 2 + m_stick);
    endtask

    task automatic wait_ticks(input int n);
        int got = 0;
        for (int k = 0; k < (n + 2) * SD && got < n; k++) begin
            cyc();
            if (m_stick != 0) got++;
        end
        if (got < n) begin
            errors++;
            $display("FAIL tick_timeout: got %0d ticks expected %0d", got, n);
        end
    endtask

    task automatic do_stop();
        stp = 1'b1;
        cyc();
        stp = 1'b0;
    endtask

    task automatic do_trig(input int p, input int a, input int d, input int s);
        per_v = PW'(p); amp_v = (DW-1)'(a); dec_v = KW'(d); swp_v = PW'(s);
        trig  = 1'b1;
        cyc();
        trig  = 1'b0;
    endtask

    typedef struct {
        int period;
        int amp;
        int decay;
        int ticks;
        int exp_duty;
        int exp_busy;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // Trigger lands one clock after a tick; at tick j the phase has seen
        // 16*j-2 tone clocks, so phase = floor((16j-2)/max(period,1)) mod 2.
        vecs[0]  = '{64, 100, 0, 1, 28,  1};
        vecs[1]  = '{64, 100, 0, 5, 228, 1};
        vecs[2]  = '{8,  100, 0, 1, 228, 1};
        vecs[3]  = '{0,  10,  0, 2, 118, 1};
        vecs[4]  = '{4,  10,  0, 1, 138, 1};
        vecs[5]  = '{2,  3,   1, 1, 131, 1};
        vecs[6]  = '{2,  3,   1, 3, 129, 1};
        vecs[7]  = '{2,  3,   1, 4, 128, 0};
        vecs[8]  = '{0,  0,   0, 1, 128, 0};
        vecs[9]  = '{2,  5,   2, 3, 132, 1};
        vecs[10] = '{7,  60,  0, 2, 68,  1};

        // Reset held three cycles.
        rst = 1'b1;
        repeat (3) cyc();
        chk("reset_duty", int'(duty_o), MID);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_tick", int'(sample_tick_o), 0);
        rst = 1'b0;
        wait_ticks(2);
        chk("idle_duty", int'(duty_o), MID);
        chk("idle_tick", int'(sample_tick_o), 1);

        // Table of single notes.
        foreach (vecs[i]) begin
            do_stop();
            wait_ticks(1);
            do_trig(vecs[i].period, vecs[i].amp, vecs[i].decay, 0);
            wait_ticks(vecs[i].ticks);
            chk($sformatf("vec%0d_duty", i), int'(duty_o), vecs[i].exp_duty);
            chk($sformatf("vec%0d_busy", i), int'(busy_o), vecs[i].exp_busy);
        end

        // Retrigger mid-note: new amplitude and phase restarted at 0.
        do_stop();
        wait_ticks(1);
        do_trig(64, 50, 0, 0);
        wait_ticks(2);
        chk("note50_duty", int'(duty_o), 78);
        do_trig(64, 120, 0, 0);
        wait_ticks(1);
        chk("retrig120_duty", int'(duty_o), 8);

        // stop and trigger together: stop wins, duty forced to MID at once.
        stp = 1'b1;
        do_trig(64, 120, 0, 0);
        stp = 1'b0;
        chk("stop_trig_duty", int'(duty_o), MID);
        chk("stop_trig_busy", int'(busy_o), 0);

        // Sustained note stays busy for 10,000 cycles.
        wait_ticks(1);
        do_trig(64, 100, 0, 0);
        begin
            int drops = 0;
            for (int k = 0; k < 10000; k++) begin
                cyc();
                if (busy_o !== 1'b1) drops++;
            end
            chk("sustain_busy_drops", drops, 0);
        end

        // Randomized run against the model.
        do_stop();
        for (int k = 0; k < 20000; k++) begin
            rst   = ($urandom_range(0, 1999) == 0);
            trig  = ($urandom_range(0, 59) == 0);
            stp   = ($urandom_range(0, 299) == 0);
            per_v = ($urandom_range(0, 3) == 0) ? PW'($urandom_range(0, 3))
                                                : PW'($urandom_range(4, 40));
            amp_v = (DW-1)'($urandom_range(0, 127));
            dec_v = KW'($urandom_range(0, 3));
            swp_v = ($urandom_range(0, 9) == 0) ? PW'($urandom_range(0, 65535))
                                                : PW'($urandom_range(0, 5));
            cyc();
        end
        rst = 1'b0; trig = 1'b0; stp = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
